stg_2_id: RTL and testbench



---
 rtl/stg_2_id_pkg.sv | 55 +++++
 rtl/stg_2_id_register_file.sv | 40 ++++
 rtl/stg_2_id.sv | 83 ++++++++
 tb/tb_stg_2_id.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stg_2_id_pkg.sv
// Shared definitions for the decode stage: widths, opcode enum, decoded bundle and
// register-usage helpers. The optional ID_BYPASS_EN macro is consumed by the register file.
package stg_2_id_pkg;

  localparam int INSTR_W      = 16;
  localparam int INSTR_ADDR_W = 10;
  localparam int DATA_W       = 16;
  localparam int NUM_REGS     = 16;
  localparam int REG_ADDR_W   = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_ADDI  = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7,
    OP_BEQ   = 4'd8
  } opcode_e;

  typedef struct packed {
    logic                    valid;
    opcode_e                 op;
    logic [REG_ADDR_W-1:0]   rd;
    logic [DATA_W-1:0]       a;
    logic [DATA_W-1:0]       b;
    logic [DATA_W-1:0]       imm;
    logic [INSTR_ADDR_W-1:0] pc;
  } bundle_t;

  function automatic logic op_known(input logic [3:0] op);
    return op <= OP_BEQ;
  endfunction

  function automatic logic uses_rs1(input logic [3:0] op);
    return op_known(op) && (op != OP_NOP);
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STORE, OP_BEQ: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stg_2_id_register_file.sv
// 16-entry, two async read / one sync write register file with r0 hardwired to zero.
// With ID_BYPASS_EN defined, a same-cycle write is forwarded to matching reads.
module stg_2_id_register_file
  import stg_2_id_pkg::*;
(
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro;
  // that is intended, since software relies on every register reading zero after reset.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    if (addr == '0) return '0;
`ifdef ID_BYPASS_EN
    if (wr_en && (wr_addr == addr)) return wr_data;
`endif
    return regs[addr];
  endfunction

  assign rd_data_a = read_port(rd_addr_a);
  assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: rtl/stg_2_id.sv
// Instruction decode stage: field split, operand read, load-use stall and EX bundle register.
// Same-cycle writeback forwarding is enabled by defining ID_BYPASS_EN.
module stg_2_id
  import stg_2_id_pkg::*;
(
  input  logic                    sys_clock,
  input  logic                    reset,
  input  logic [INSTR_W-1:0]      r_id_instr,
  input  logic [INSTR_ADDR_W-1:0] r_id_pc,
  input  logic                    ex_flush,
  input  logic                    wb_en,
  input  logic [REG_ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  output logic                    id_stall,
  output logic                    r_ex_valid,
  output logic [3:0]              r_ex_op,
  output logic [REG_ADDR_W-1:0]   r_ex_rd,
  output logic [DATA_W-1:0]       r_ex_a,
  output logic [DATA_W-1:0]       r_ex_b,
  output logic [DATA_W-1:0]       r_ex_imm,
  output logic [INSTR_ADDR_W-1:0] r_ex_pc
);

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0]     rs1_val, rs2_val;
  logic                  load_use;
  bundle_t               r_ex, next_ex;

  assign op  = r_id_instr[15:12];
  assign rd  = r_id_instr[11:8];
  assign rs1 = r_id_instr[7:4];
  assign rs2 = r_id_instr[3:0];

  stg_2_id_register_file u_register_file (
    .sys_clock (sys_clock),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (rs1),
    .rd_data_a (rs1_val),
    .rd_addr_b (rs2),
    .rd_data_b (rs2_val)
  );

  // A load in EX has no data until MEM, so any consumer right behind it must wait one slot.
  assign load_use = r_ex.valid && (r_ex.op == OP_LOAD) && (r_ex.rd != '0) &&
                    ((uses_rs1(op) && (rs1 == r_ex.rd)) ||
                     (uses_rs2(op) && (rs2 == r_ex.rd)));

  // NOTE: every output of this block is defaulted first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_ex  = '0;
    id_stall = load_use && !ex_flush;
    if (!ex_flush && !load_use) begin
      next_ex.valid = op_known(op) && (op != OP_NOP);
      next_ex.op    = op_known(op) ? opcode_e'(op) : OP_NOP;
      next_ex.rd    = rd;
      next_ex.a     = rs1_val;
      next_ex.b     = rs2_val;
      next_ex.imm   = {{(DATA_W-4){r_id_instr[3]}}, r_id_instr[3:0]};
      next_ex.pc    = r_id_pc;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clock) begin
    if (reset) r_ex <= '0;
    else       r_ex <= next_ex;
  end

  assign r_ex_valid = r_ex.valid;
  assign r_ex_op    = r_ex.op;
  assign r_ex_rd    = r_ex.rd;
  assign r_ex_a     = r_ex.a;
  assign r_ex_b     = r_ex.b;
  assign r_ex_imm   = r_ex.imm;
  assign r_ex_pc    = r_ex.pc;

endmodule

// File: tb/tb_stg_2_id.sv
// Table-driven bench for stg_2_id: each row is one cycle of stimulus with its expected
// combinational stall and the bundle expected after the edge (checked through a scoreboard).
module tb_stg_2_id;
  import stg_2_id_pkg::*;

  logic                    sys_clock = 1'b0;
  logic                    reset;
  logic [INSTR_W-1:0]      r_id_instr;
  logic [INSTR_ADDR_W-1:0] r_id_pc;
  logic                    ex_flush;
  logic                    wb_en;
  logic [REG_ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]       wb_data;
  logic                    id_stall;
  logic                    r_ex_valid;
  logic [3:0]              r_ex_op;
  logic [REG_ADDR_W-1:0]   r_ex_rd;
  logic [DATA_W-1:0]       r_ex_a, r_ex_b, r_ex_imm;
  logic [INSTR_ADDR_W-1:0] r_ex_pc;

  stg_2_id dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .r_id_instr (r_id_instr),
    .r_id_pc    (r_id_pc),
    .ex_flush   (ex_flush),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .id_stall   (id_stall),
    .r_ex_valid (r_ex_valid),
    .r_ex_op    (r_ex_op),
    .r_ex_rd    (r_ex_rd),
    .r_ex_a     (r_ex_a),
    .r_ex_b     (r_ex_b),
    .r_ex_imm   (r_ex_imm),
    .r_ex_pc    (r_ex_pc)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic                    rst;
    logic [INSTR_W-1:0]      instr;
    logic [INSTR_ADDR_W-1:0] pc;
    logic                    flush;
    logic                    wen;
    logic [REG_ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]       wdata;
    logic                    exp_stall;
    bundle_t                 exp;
  } vec_t;

  vec_t    vecs[$];
  bundle_t sb[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic bundle_t bnd(input logic v, input opcode_e op, input logic [3:0] rd,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] imm, input logic [9:0] pc);
    bundle_t r;
    r.valid = v; r.op = op; r.rd = rd; r.a = a; r.b = b; r.imm = imm; r.pc = pc;
    return r;
  endfunction

  function automatic bundle_t dut_bundle();
    return bnd(r_ex_valid, opcode_e'(r_ex_op), r_ex_rd, r_ex_a, r_ex_b, r_ex_imm, r_ex_pc);
  endfunction

  function automatic vec_t mk(input logic rst, input logic [15:0] instr, input logic [9:0] pc,
                              input logic flush, input logic wen, input logic [3:0] waddr,
                              input logic [15:0] wdata, input logic stall, input bundle_t exp);
    vec_t v;
    v.rst = rst; v.instr = instr; v.pc = pc; v.flush = flush; v.wen = wen;
    v.waddr = waddr; v.wdata = wdata; v.exp_stall = stall; v.exp = exp;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t         bubble;
    bundle_t         got;
    logic [15:0]     r7_same;
`ifdef ID_BYPASS_EN
    r7_same = 16'h00A5;
`else
    r7_same = 16'h0000;
`endif
    bubble = '0;

    reset = 1'b1; r_id_instr = '0; r_id_pc = '0; ex_flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge sys_clock);
    @(negedge sys_clock);
    reset = 1'b0;
    #1;
    check("reset_bundle", 0, 80'(dut_bundle()), 80'(bubble));
    check("reset_stall", 0, 80'(id_stall), 80'(1'b0));

    //           rst instr     pc  fl wen wa  wdata    stall expected bundle
    vecs.push_back(mk(0, 16'h510D, 1,  0, 0, 0, 16'h0000, 0, bnd(1, OP_ADDI,  1, 16'h0000, 16'h0000, 16'hFFFD, 1)));
    vecs.push_back(mk(0, 16'h0000, 2,  0, 1, 2, 16'h1234, 0, bnd(0, OP_NOP,   0, 16'h0000, 16'h0000, 16'h0000, 2)));
    vecs.push_back(mk(0, 16'h1322, 3,  0, 1, 0, 16'hBEEF, 0, bnd(1, OP_ADD,   3, 16'h1234, 16'h1234, 16'h0002, 3)));
    vecs.push_back(mk(0, 16'h1602, 4,  0, 1, 1, 16'h0011, 0, bnd(1, OP_ADD,   6, 16'h0000, 16'h1234, 16'h0002, 4)));
    vecs.push_back(mk(0, 16'h6410, 5,  0, 0, 0, 16'h0000, 0, bnd(1, OP_LOAD,  4, 16'h0011, 16'h0000, 16'h0000, 5)));
    vecs.push_back(mk(0, 16'h1540, 6,  0, 0, 0, 16'h0000, 1, bubble));
    vecs.push_back(mk(0, 16'h1540, 6,  0, 0, 0, 16'h0000, 0, bnd(1, OP_ADD,   5, 16'h0000, 16'h0000, 16'h0000, 6)));
    vecs.push_back(mk(0, 16'h6410, 7,  0, 0, 0, 16'h0000, 0, bnd(1, OP_LOAD,  4, 16'h0011, 16'h0000, 16'h0000, 7)));
    vecs.push_back(mk(0, 16'h5564, 8,  0, 0, 0, 16'h0000, 0, bnd(1, OP_ADDI,  5, 16'h0000, 16'h0000, 16'h0004, 8)));
    vecs.push_back(mk(0, 16'h6410, 9,  0, 0, 0, 16'h0000, 0, bnd(1, OP_LOAD,  4, 16'h0011, 16'h0000, 16'h0000, 9)));
    vecs.push_back(mk(0, 16'h1540, 10, 1, 0, 0, 16'h0000, 0, bubble));
    vecs.push_back(mk(0, 16'h9123, 11, 0, 0, 0, 16'h0000, 0, bnd(0, OP_NOP,   1, 16'h1234, 16'h0000, 16'h0003, 11)));
    vecs.push_back(mk(0, 16'h1870, 12, 0, 1, 7, 16'h00A5, 0, bnd(1, OP_ADD,   8, r7_same,  16'h0000, 16'h0000, 12)));
    vecs.push_back(mk(0, 16'h1870, 13, 0, 0, 0, 16'h0000, 0, bnd(1, OP_ADD,   8, 16'h00A5, 16'h0000, 16'h0000, 13)));
    vecs.push_back(mk(0, 16'h6010, 14, 0, 0, 0, 16'h0000, 0, bnd(1, OP_LOAD,  0, 16'h0011, 16'h0000, 16'h0000, 14)));
    vecs.push_back(mk(0, 16'h1500, 15, 0, 0, 0, 16'h0000, 0, bnd(1, OP_ADD,   5, 16'h0000, 16'h0000, 16'h0000, 15)));
    vecs.push_back(mk(0, 16'h6910, 16, 0, 0, 0, 16'h0000, 0, bnd(1, OP_LOAD,  9, 16'h0011, 16'h0000, 16'h0000, 16)));
    vecs.push_back(mk(0, 16'h7019, 17, 0, 0, 0, 16'h0000, 1, bubble));
    vecs.push_back(mk(0, 16'h7019, 17, 0, 0, 0, 16'h0000, 0, bnd(1, OP_STORE, 0, 16'h0011, 16'h0000, 16'hFFF9, 17)));
    // Reset mid-stream together with a writeback: the write must be dropped.
    vecs.push_back(mk(1, 16'h1322, 20, 0, 1, 2, 16'h5555, 0, bubble));
    vecs.push_back(mk(0, 16'h1322, 21, 0, 0, 0, 16'h0000, 0, bnd(1, OP_ADD,   3, 16'h0000, 16'h0000, 16'h0002, 21)));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sys_clock);
      reset      = vecs[i].rst;
      r_id_instr = vecs[i].instr;
      r_id_pc    = vecs[i].pc;
      ex_flush   = vecs[i].flush;
      wb_en      = vecs[i].wen;
      wb_addr    = vecs[i].waddr;
      wb_data    = vecs[i].wdata;
      #1;
      check("id_stall", i, 80'(id_stall), 80'(vecs[i].exp_stall));
      sb.push_back(vecs[i].exp);
      @(posedge sys_clock);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard[%0d]: got empty queue, expected one entry", i);
      end else begin
        got = dut_bundle();
        check("bundle", i, 80'(got), 80'(sb.pop_front()));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
